romulus_tbc_sequencer: RTL and testbench

Control FSM that sequences one Skinny-based tweakable block cipher (TBC) call on the Romulus datapath. It loads the key and tweak registers from the bus and triggers the domain-separator reload. It then steps the round function for ROUNDS rounds, generating the 6-bit round constant and the per-round clock ring, and finally issues the tweakey correction step. It also performs standalone block-counter increments between TBC calls. It sits between the mode-level controller and the datapath enable/reset pins.

---
 rtl/romulus_tbc_sequencer_if.sv | 43 ++++
 rtl/romulus_tbc_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_romulus_tbc_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/romulus_tbc_sequencer_if.sv
// Mode-controller <-> TBC sequencer bundle: call handshake, key/tweak beat
// handshakes and the datapath enable/reset strobes driven by the sequencer.
interface romulus_tbc_sequencer_if #(
  parameter int unsigned CLKS_PER_RND = 1
);
  logic                    start;
  logic                    new_key;
  logic                    cnt_inc;
  logic                    ready;
  logic                    done;
  logic                    sdi_valid;
  logic                    sdi_ready;
  logic                    pdi_valid;
  logic                    pdi_ready;
  logic                    xrst;
  logic                    yrst;
  logic                    zrst;
  logic                    xen;
  logic                    xenc;
  logic                    yen;
  logic                    yenc;
  logic                    zen;
  logic                    zenc;
  logic                    sen;
  logic                    senc;
  logic                    correct_cnt;
  logic [5:0]              constant;
  logic [CLKS_PER_RND-1:0] ring_en;

  modport master (
    output start, new_key, cnt_inc, sdi_valid, pdi_valid,
    input  ready, done, sdi_ready, pdi_ready, xrst, yrst, zrst,
           xen, xenc, yen, yenc, zen, zenc, sen, senc, correct_cnt,
           constant, ring_en
  );

  modport slave (
    input  start, new_key, cnt_inc, sdi_valid, pdi_valid,
    output ready, done, sdi_ready, pdi_ready, xrst, yrst, zrst,
           xen, xenc, yen, yenc, zen, zenc, sen, senc, correct_cnt,
           constant, ring_en
  );
endinterface

// File: rtl/romulus_tbc_sequencer.sv
// Skinny TBC call sequencer for the Romulus datapath: key/tweak load, rounds,
// tweakey correction and counter-only increments. Option: ROMULUS_SEQ_KEY_REUSE_EN.
module romulus_tbc_sequencer #(
  parameter int unsigned BUSW         = 32,
  parameter int unsigned KEYSHARES    = 1,
  parameter int unsigned ROUNDS       = 40,
  parameter int unsigned CLKS_PER_RND = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  romulus_tbc_sequencer_if.slave   bus
);

  localparam int unsigned KB   = 128 * KEYSHARES / BUSW;
  localparam int unsigned TB   = 128 / BUSW;
  localparam int unsigned BMAX = (KB > TB) ? KB : TB;
  localparam int unsigned BCW  = $clog2(BMAX + 1);
  localparam int unsigned RCW  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDKEY,
    S_LDTWK,
    S_RUN,
    S_CORRECT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [BCW-1:0]          beat_q, beat_d;
  logic [RCW-1:0]          round_q, round_d;
  logic [5:0]              rc_q, rc_d;
  logic [CLKS_PER_RND-1:0] ring_q, ring_d;
  logic                    cnt_q, cnt_d;
  logic                    last_phase;

  function automatic logic [5:0] rc_step(input logic [5:0] r);
    return {r[4:0], r[5] ^ r[4] ^ 1'b1};
  endfunction

  assign last_phase = ring_q[CLKS_PER_RND-1];

`ifndef ROMULUS_SEQ_KEY_REUSE_EN
  logic unused_new_key;
  assign unused_new_key = bus.new_key;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      round_q <= '0;
      rc_q    <= '0;
      ring_q  <= '0;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      round_q <= round_d;
      rc_q    <= rc_d;
      ring_q  <= ring_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    round_d = round_q;
    rc_d    = rc_q;
    ring_d  = '0;
    cnt_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          beat_d  = '0;
`ifdef ROMULUS_SEQ_KEY_REUSE_EN
          state_d = bus.new_key ? S_LDKEY : S_LDTWK;
`else
          state_d = S_LDKEY;
`endif
        end else begin
          // counter strobe is registered to keep the input off the output path
          cnt_d = bus.cnt_inc;
        end
      end
      S_LDKEY: begin
        if (bus.sdi_valid) begin
          if (beat_q == BCW'(KB - 1)) begin
            beat_d  = '0;
            state_d = S_LDTWK;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      S_LDTWK: begin
        if (bus.pdi_valid) begin
          if (beat_q == BCW'(TB - 1)) begin
            beat_d  = '0;
            state_d = S_RUN;
            round_d = '0;
            rc_d    = rc_step(6'h00);
            ring_d  = CLKS_PER_RND'(1);
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      S_RUN: begin
        // rotate-left that also degenerates correctly for a 1-bit ring
        ring_d = (ring_q << 1) | (ring_q >> (CLKS_PER_RND - 1));
        if (last_phase) begin
          if (round_q == RCW'(ROUNDS - 1)) begin
            state_d = S_CORRECT;
            ring_d  = '0;
            rc_d    = '0;
          end else begin
            round_d = round_q + RCW'(1);
            rc_d    = rc_step(rc_q);
          end
        end
      end
      S_CORRECT: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready       = 1'b0;
    bus.done        = 1'b0;
    bus.sdi_ready   = 1'b0;
    bus.pdi_ready   = 1'b0;
    bus.xrst        = 1'b0;
    bus.yrst        = 1'b0;
    bus.zrst        = 1'b0;
    bus.xen         = 1'b0;
    bus.xenc        = 1'b0;
    bus.yen         = 1'b0;
    bus.yenc        = 1'b0;
    bus.zen         = 1'b0;
    bus.zenc        = 1'b0;
    bus.sen         = 1'b0;
    bus.senc        = 1'b0;
    bus.correct_cnt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.ready       = 1'b1;
        bus.zen         = cnt_q;
        bus.correct_cnt = cnt_q;
      end
      S_LDKEY: begin
        bus.sdi_ready = 1'b1;
        bus.xrst      = bus.sdi_valid;
      end
      S_LDTWK: begin
        bus.pdi_ready = 1'b1;
        bus.yrst      = bus.pdi_valid;
        bus.zrst      = bus.pdi_valid && (beat_q == BCW'(TB - 1));
      end
      S_RUN: begin
        bus.senc = 1'b1;
        bus.sen  = last_phase;
        bus.xen  = last_phase;
        bus.xenc = last_phase;
        bus.yen  = last_phase;
        bus.yenc = last_phase;
        bus.zen  = last_phase;
        bus.zenc = last_phase;
      end
      S_CORRECT: begin
        bus.xen = 1'b1;
        bus.yen = 1'b1;
        bus.zen = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.constant = rc_q;
  assign bus.ring_en  = ring_q;

endmodule

// File: tb/tb_romulus_tbc_sequencer.sv
// Randomized bench: per-call expected output traces are built from the
// call's phase structure and compared cycle by cycle on two ring widths.
module tb_romulus_tbc_sequencer;

  localparam int unsigned KB     = 4;
  localparam int unsigned TB     = 4;
  localparam int unsigned ROUNDS = 40;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       new_key;
    logic       cnt_inc;
    logic       sv;
    logic       pv;
    logic [7:0] lat;
  } stim_t;

  typedef struct packed {
    logic       ready;
    logic       done;
    logic       sdi_ready;
    logic       pdi_ready;
    logic       xrst;
    logic       yrst;
    logic       zrst;
    logic       xen;
    logic       xenc;
    logic       yen;
    logic       yenc;
    logic       zen;
    logic       zenc;
    logic       sen;
    logic       senc;
    logic       correct_cnt;
    logic [5:0] k;
    logic [1:0] ring;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t_start = 1'b0, t_nk = 1'b0, t_cnt = 1'b0, t_sv = 1'b0, t_pv = 1'b0;
  logic sel = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  stim_t sq[$];
  out_t  eq[$];
  bit    pend_cnt = 1'b0;

  always #5 clk = ~clk;

  romulus_tbc_sequencer_if #(.CLKS_PER_RND(1)) ifa ();
  romulus_tbc_sequencer_if #(.CLKS_PER_RND(2)) ifb ();

  assign ifa.start     = t_start & ~sel;
  assign ifa.new_key   = t_nk    & ~sel;
  assign ifa.cnt_inc   = t_cnt   & ~sel;
  assign ifa.sdi_valid = t_sv    & ~sel;
  assign ifa.pdi_valid = t_pv    & ~sel;
  assign ifb.start     = t_start & sel;
  assign ifb.new_key   = t_nk    & sel;
  assign ifb.cnt_inc   = t_cnt   & sel;
  assign ifb.sdi_valid = t_sv    & sel;
  assign ifb.pdi_valid = t_pv    & sel;

  romulus_tbc_sequencer #(
    .BUSW(32), .KEYSHARES(1), .ROUNDS(40), .CLKS_PER_RND(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  romulus_tbc_sequencer #(
    .BUSW(32), .KEYSHARES(1), .ROUNDS(40), .CLKS_PER_RND(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  out_t oa, ob;
  assign oa = {ifa.ready, ifa.done, ifa.sdi_ready, ifa.pdi_ready, ifa.xrst, ifa.yrst,
               ifa.zrst, ifa.xen, ifa.xenc, ifa.yen, ifa.yenc, ifa.zen, ifa.zenc,
               ifa.sen, ifa.senc, ifa.correct_cnt, ifa.constant, 1'b0, ifa.ring_en};
  assign ob = {ifb.ready, ifb.done, ifb.sdi_ready, ifb.pdi_ready, ifb.xrst, ifb.yrst,
               ifb.zrst, ifb.xen, ifb.xenc, ifb.yen, ifb.yenc, ifb.zen, ifb.zenc,
               ifb.sen, ifb.senc, ifb.correct_cnt, ifb.constant, ifb.ring_en};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] lfsr(input logic [5:0] r);
    return {r[4:0], r[5] ^ r[4] ^ 1'b1};
  endfunction

  function automatic out_t idle_rec(input bit strobe);
    out_t o = '0;
    o.ready       = 1'b1;
    o.zen         = strobe;
    o.correct_cnt = strobe;
    return o;
  endfunction

  function automatic stim_t rnd_stim(input int unsigned vpct);
    stim_t s = '0;
    s.sv      = ($urandom_range(99) < vpct);
    s.pv      = ($urandom_range(99) < vpct);
    s.start   = ($urandom_range(3) == 0);
    s.cnt_inc = ($urandom_range(3) == 0);
    s.new_key = 1'($urandom);
    return s;
  endfunction

  task automatic push(input stim_t s, input out_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic gen_idle(input int unsigned n, input int unsigned cnt_pct);
    stim_t s;
    for (int unsigned i = 0; i < n; i++) begin
      s         = '0;
      s.cnt_inc = ($urandom_range(99) < cnt_pct);
      s.sv      = 1'($urandom);
      s.pv      = 1'($urandom);
      push(s, idle_rec(pend_cnt));
      pend_cnt  = s.cnt_inc;
    end
  endtask

  // abort_rnd >= 0 asserts rst on the first clock of that round
  task automatic gen_call(input int unsigned cpr, input bit nk, input int unsigned vpct,
                          input bit with_cnt, input int abort_rnd);
    stim_t       s;
    out_t        e;
    bit          key_eff;
    int unsigned n;
    logic [5:0]  rc;
`ifdef ROMULUS_SEQ_KEY_REUSE_EN
    key_eff = nk;
`else
    key_eff = 1'b1;
`endif
    s         = '0;
    s.start   = 1'b1;
    s.new_key = nk;
    s.cnt_inc = with_cnt;
    s.sv      = 1'($urandom);
    s.pv      = 1'($urandom);
    s.lat     = (vpct >= 100 && abort_rnd < 0) ?
                8'(1 + KB * key_eff + TB + ROUNDS * cpr + 1) : 8'd0;
    push(s, idle_rec(pend_cnt));
    pend_cnt = 1'b0;
    if (key_eff) begin
      n = 0;
      while (n < KB) begin
        s = rnd_stim(vpct);
        e = '0;
        e.sdi_ready = 1'b1;
        e.xrst      = s.sv;
        n += s.sv;
        push(s, e);
      end
    end
    n = 0;
    while (n < TB) begin
      s = rnd_stim(vpct);
      e = '0;
      e.pdi_ready = 1'b1;
      e.yrst      = s.pv;
      e.zrst      = s.pv && (n == TB - 1);
      n += s.pv;
      push(s, e);
    end
    rc = 6'h00;
    for (int r = 0; r < int'(ROUNDS); r++) begin
      rc = lfsr(rc);
      for (int unsigned p = 0; p < cpr; p++) begin
        s = rnd_stim(vpct);
        e = '0;
        e.senc = 1'b1;
        e.k    = rc;
        e.ring = 2'(1 << p);
        if (p == cpr - 1) begin
          e.sen = 1'b1; e.xen = 1'b1; e.xenc = 1'b1;
          e.yen = 1'b1; e.yenc = 1'b1; e.zen = 1'b1; e.zenc = 1'b1;
        end
        if (r == abort_rnd && p == 0) begin
          s.rst = 1'b1;
          push(s, e);
          push('0, idle_rec(1'b0));
          return;
        end
        push(s, e);
      end
    end
    e = '0;
    e.xen = 1'b1; e.yen = 1'b1; e.zen = 1'b1;
    push(rnd_stim(vpct), e);
    e = '0;
    e.done = 1'b1;
    push(rnd_stim(vpct), e);
    push('0, idle_rec(1'b0));
  endtask

  task automatic run_queue(input logic s_sel);
    stim_t       st;
    out_t        ex, obv;
    int unsigned cyc = 0, t0 = 0, lat = 0;
    sel = s_sel;
    while (sq.size() > 0) begin
      st = sq.pop_front();
      ex = eq.pop_front();
      @(negedge clk);
      rst     = st.rst;
      t_start = st.start;
      t_nk    = st.new_key;
      t_cnt   = st.cnt_inc;
      t_sv    = st.sv;
      t_pv    = st.pv;
      #1;
      obv = sel ? ob : oa;
      check_eq($sformatf("trace%0d@%0d", s_sel, cyc), 32'(obv), 32'(ex));
      if (st.start && !st.rst && st.lat != 0 && obv.ready && lat == 0) begin
        t0  = cyc;
        lat = st.lat;
      end
      if (obv.done && lat != 0) begin
        check_eq("latency", 32'(cyc - t0), 32'(lat));
        lat = 0;
      end
      cyc++;
    end
    @(negedge clk);
    t_start = 1'b0; t_nk = 1'b0; t_cnt = 1'b0; t_sv = 1'b0; t_pv = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);

    // directed: reset state, nominal calls, stalls, counter strobes, abort
    gen_idle(3, 0);
    gen_call(1, 1'b1, 100, 1'b0, -1);
    gen_idle(2, 0);
    gen_call(1, 1'b1, 60, 1'b0, -1);
    gen_call(1, 1'b0, 100, 1'b0, -1);
    gen_idle(1, 100);
    gen_idle(3, 0);
    gen_idle(1, 100);
    gen_call(1, 1'b1, 100, 1'b1, -1);
    gen_call(1, 1'b1, 100, 1'b0, 17);
    gen_call(1, 1'b1, 100, 1'b0, -1);
    gen_idle(1, 0);
    run_queue(1'b0);

    gen_idle(2, 0);
    gen_call(2, 1'b1, 100, 1'b0, -1);
    gen_call(2, 1'($urandom), 70, 1'b0, -1);
    gen_call(2, 1'b1, 100, 1'b0, 5);
    gen_idle(1, 0);
    run_queue(1'b1);

    for (int unsigned i = 0; i < 8; i++) begin
      gen_idle($urandom_range(5, 1), 30);
      gen_call(1, 1'($urandom), $urandom_range(100, 40), 1'($urandom),
               ($urandom_range(4) == 0) ? int'($urandom_range(39)) : -1);
    end
    gen_idle(1, 0);
    run_queue(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
